hoop_pass_scorer: RTL and testbench

Downstream consumer of the falling-hoop mover. Each frame it samples the hoop's top-left position and the player's top-left position. It decides whether the player flew cleanly through the hoop opening, clipped the rim, or missed the hoop entirely. It keeps a combo multiplier and a saturating 4-digit BCD score that feeds the score display.

---
 rtl/hoop_score_pkg.sv | 30 +++
 rtl/bcd4_add_sat.sv | 39 +++
 rtl/hoop_pass_scorer.sv | 220 ++++++++++++++++++++++
 tb/tb_hoop_pass_scorer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hoop_score_pkg.sv
// hoop_score_pkg: shared types and tuning constants for the hoop pass scorer
// and the BCD score path.
package hoop_score_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        INSIDE = 2'd1,
        SCORED = 2'd2,
        MISSED = 2'd3
    } hoop_state_t;

    typedef logic [15:0] bcd4_t;

    localparam bcd4_t BCD_MAX = 16'h9999;

    // Geometry of the hoop opening and the player sprite, in pixels.
    localparam int HOOP_W        = 28;
    localparam int RING_MARGIN_X = 6;
    localparam int RING_TOP_Y    = 8;
    localparam int RING_H        = 20;
    localparam int PLAYER_W      = 32;
    localparam int PLAYER_H      = 32;

    // Scoring rules.
    localparam int    MIN_INSIDE_FRAMES    = 3;
    localparam bcd4_t BASE_POINTS_BCD      = 16'h0010;
    localparam int    MAX_COMBO            = 7;
    localparam int    COMBO_TIMEOUT_FRAMES = 240;

endpackage

// File: rtl/bcd4_add_sat.sv
// bcd4_add_sat: combinational 4-digit BCD adder. Digits ripple a decimal
// carry; a carry out of the top digit clamps the result to BCD_MAX.
// Inputs are assumed to hold valid BCD digits.
module bcd4_add_sat
    import hoop_score_pkg::*;
(
    input  bcd4_t i_a,
    input  bcd4_t i_b,
    output bcd4_t o_sum
);

    bcd4_t w_raw_sum;
    logic  w_carry_out;

    // Ripple the four decimal digits, correcting any digit above 9.
    always_comb begin
        logic [4:0] digit_sum;
        logic       carry;
        // NOTE: every variable gets a value before any branch, so no path can
        // leave one unassigned and infer a latch.
        digit_sum   = 5'd0;
        carry       = 1'b0;
        w_raw_sum   = '0;
        w_carry_out = 1'b0;
        for (int d = 0; d < 4; d++) begin
            digit_sum = {1'b0, i_a[4*d +: 4]} + {1'b0, i_b[4*d +: 4]} + {4'b0000, carry};
            carry     = (digit_sum > 5'd9);
            if (carry) begin
                // Adding 6 wraps the low nibble around to (sum - 10).
                digit_sum = digit_sum + 5'd6;
            end
            w_raw_sum[4*d +: 4] = digit_sum[3:0];
        end
        w_carry_out = carry;
    end

    assign o_sum = w_carry_out ? BCD_MAX : w_raw_sum;

endmodule

// File: rtl/hoop_pass_scorer.sv
// hoop_pass_scorer: decides each frame whether the player passed cleanly
// through the falling hoop, clipped its rim or missed it, and keeps a combo
// multiplier plus a saturating 4-digit BCD score.
// Optional feature: define HOOP_SCORE_COMBO_TIMEOUT_EN to make the combo decay
// to zero after COMBO_TIMEOUT_FRAMES unpaused frames without a score.
module hoop_pass_scorer
    import hoop_score_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               pause,
    input  logic signed [10:0] hoopTopLeftX,
    input  logic signed [10:0] hoopTopLeftY,
    input  logic signed [10:0] playerTopLeftX,
    input  logic signed [10:0] playerTopLeftY,
    input  logic               rimCollision,
    output bcd4_t              score,
    output logic               scorePulse,
    output logic [2:0]         comboLevel,
    output logic [1:0]         hoopState
);

    // Opening bounds relative to the hoop top-left, and player centre offsets.
    localparam logic signed [11:0] C_WIN_X_LO   = 12'(RING_MARGIN_X);
    localparam logic signed [11:0] C_WIN_X_HI   = 12'(HOOP_W - RING_MARGIN_X);
    localparam logic signed [11:0] C_WIN_Y_LO   = 12'(RING_TOP_Y);
    localparam logic signed [11:0] C_WIN_Y_HI   = 12'(RING_TOP_Y + RING_H);
    localparam logic signed [11:0] C_HALF_W     = 12'(PLAYER_W / 2);
    localparam logic signed [11:0] C_HALF_H     = 12'(PLAYER_H / 2);
    localparam logic [3:0]         C_LAST_COUNT = 4'(MIN_INSIDE_FRAMES - 1);
    localparam logic [2:0]         C_MAX_COMBO  = 3'(MAX_COMBO);

    logic signed [10:0] r_hoop_x;
    logic signed [10:0] r_hoop_y;
    logic signed [10:0] r_player_x;
    logic signed [10:0] r_player_y;
    logic signed [10:0] r_prev_hoop_y;
    logic               r_eval;
    logic               r_rim_latch;
    hoop_state_t        r_state;
    logic [3:0]         r_inside_cnt;
    logic [2:0]         r_combo;
    logic [3:0]         r_pending;
    bcd4_t              r_score;
    logic               r_score_pulse;

    logic signed [11:0] w_hx;
    logic signed [11:0] w_hy;
    logic signed [11:0] w_cx;
    logic signed [11:0] w_cy;
    logic               w_in_win;
    logic               w_respawn;
    logic               w_eval;
    logic               w_live;
    logic               w_miss;
    logic               w_award_start;
    logic               w_timeout;
    logic [3:0]         w_pending_dec;
    logic [4:0]         w_pending_sum;
    bcd4_t              w_score_next;

    // Window test on the positions sampled at the last frame strobe.
    assign w_hx     = 12'(r_hoop_x);
    assign w_hy     = 12'(r_hoop_y);
    assign w_cx     = 12'(r_player_x) + C_HALF_W;
    assign w_cy     = 12'(r_player_y) + C_HALF_H;
    assign w_in_win = (w_cx >= w_hx + C_WIN_X_LO) && (w_cx < w_hx + C_WIN_X_HI) &&
                      (w_cy >= w_hy + C_WIN_Y_LO) && (w_cy < w_hy + C_WIN_Y_HI);

    // A hoop moving upward means the mover has respawned it at the top.
    assign w_respawn = (r_hoop_y < r_prev_hoop_y);
    assign w_eval    = r_eval && !pause;
    assign w_live    = (r_state == ARMED) || (r_state == INSIDE);

    // Frame outcomes that drive the combo and the award engine.
    assign w_miss        = w_eval && w_live && (w_respawn || r_rim_latch);
    assign w_award_start = w_eval && !w_respawn && !r_rim_latch && (r_state == INSIDE) &&
                           w_in_win && (r_inside_cnt == C_LAST_COUNT);

    // Sample both positions on the frame strobe; evaluate one cycle later.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hoop_x   <= '0;
            r_hoop_y   <= '0;
            r_player_x <= '0;
            r_player_y <= '0;
            r_eval     <= 1'b0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every
            // register in the design samples the same pre-edge values.
            r_eval <= startOfFrame;
            if (startOfFrame) begin
                r_hoop_x   <= hoopTopLeftX;
                r_hoop_y   <= hoopTopLeftY;
                r_player_x <= playerTopLeftX;
                r_player_y <= playerTopLeftY;
            end
        end
    end

    // Remember any rim touch since the last unpaused evaluation.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rim_latch <= 1'b0;
        end else if (w_eval) begin
            r_rim_latch <= rimCollision;
        end else if (rimCollision) begin
            r_rim_latch <= 1'b1;
        end
    end

    // Pass-tracking state machine, stepped once per unpaused frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ARMED;
            r_inside_cnt  <= 4'd0;
            r_prev_hoop_y <= '0;
        end else if (w_eval) begin
            r_prev_hoop_y <= r_hoop_y;
            if (w_respawn) begin
                r_state      <= ARMED;
                r_inside_cnt <= 4'd0;
            end else begin
                case (r_state)
                    ARMED: begin
                        if (r_rim_latch) begin
                            r_state <= MISSED;
                        end else if (w_in_win) begin
                            r_state      <= INSIDE;
                            r_inside_cnt <= 4'd1;
                        end
                    end
                    INSIDE: begin
                        if (r_rim_latch) begin
                            r_state      <= MISSED;
                            r_inside_cnt <= 4'd0;
                        end else if (w_in_win) begin
                            r_inside_cnt <= r_inside_cnt + 4'd1;
                            if (w_award_start) begin
                                r_state <= SCORED;
                            end
                        end else begin
                            r_state      <= ARMED;
                            r_inside_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        // SCORED and MISSED wait for the next respawn.
                    end
                endcase
            end
        end
    end

`ifdef HOOP_SCORE_COMBO_TIMEOUT_EN
    logic [15:0] r_idle_frames;

    assign w_timeout = w_eval && !w_award_start &&
                       (r_idle_frames == 16'(COMBO_TIMEOUT_FRAMES - 1));

    // Count unpaused frames since the last award; an award always wins.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_idle_frames <= 16'd0;
        end else if (w_award_start || w_timeout) begin
            r_idle_frames <= 16'd0;
        end else if (w_eval) begin
            r_idle_frames <= r_idle_frames + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Combo grows with each award and collapses on any miss or timeout.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_combo <= 3'd0;
        end else if (w_award_start) begin
            r_combo <= (r_combo == C_MAX_COMBO) ? r_combo : r_combo + 3'd1;
        end else if (w_miss || w_timeout) begin
            r_combo <= 3'd0;
        end
    end

    assign w_pending_dec = (r_pending != 4'd0) ? r_pending - 4'd1 : 4'd0;
    assign w_pending_sum = {1'b0, w_pending_dec} + {2'b00, r_combo} + 5'd1;

    bcd4_add_sat u_score_add (
        .i_a   (r_score),
        .i_b   (BASE_POINTS_BCD),
        .o_sum (w_score_next)
    );

    // Award engine: add one base step per cycle while steps are pending.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pending     <= 4'd0;
            r_score       <= '0;
            r_score_pulse <= 1'b0;
        end else begin
            r_score_pulse <= w_award_start;
            if (w_award_start) begin
                r_pending <= (w_pending_sum > 5'd15) ? 4'd15 : w_pending_sum[3:0];
            end else begin
                r_pending <= w_pending_dec;
            end
            if (r_pending != 4'd0) begin
                r_score <= w_score_next;
            end
        end
    end

    assign score      = r_score;
    assign scorePulse = r_score_pulse;
    assign comboLevel = r_combo;
    assign hoopState  = r_state;

endmodule

// File: tb/tb_hoop_pass_scorer.sv
// tb_hoop_pass_scorer: frame-level stimulus with a behavioural model of the
// scoring rules; awards are queued and checked by an independent monitor.
`timescale 1ns/1ps
module tb_hoop_pass_scorer;
    import hoop_score_pkg::*;

    localparam int BASE_POINTS_DEC = 10;
    localparam int SCORE_CAP       = 9999;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               pause;
    logic signed [10:0] hoopTopLeftX;
    logic signed [10:0] hoopTopLeftY;
    logic signed [10:0] playerTopLeftX;
    logic signed [10:0] playerTopLeftY;
    logic               rimCollision;
    bcd4_t              score;
    logic               scorePulse;
    logic [2:0]         comboLevel;
    logic [1:0]         hoopState;

    always #5 clk = ~clk;

    hoop_pass_scorer dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .pause          (pause),
        .hoopTopLeftX   (hoopTopLeftX),
        .hoopTopLeftY   (hoopTopLeftY),
        .playerTopLeftX (playerTopLeftX),
        .playerTopLeftY (playerTopLeftY),
        .rimCollision   (rimCollision),
        .score          (score),
        .scorePulse     (scorePulse),
        .comboLevel     (comboLevel),
        .hoopState      (hoopState)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int steps;
        int score_dec;
        int combo;
    } award_t;
    award_t exp_q[$];

    // Model of the game as seen frame by frame.
    int m_run      = 0;  // consecutive in-opening frames on the current hoop
    int m_outcome  = 0;  // 0 = undecided, 1 = scored, 2 = clipped or missed
    int m_prev_y   = 0;
    int m_combo    = 0;
    int m_score    = 0;
    bit m_rim_seen = 1'b0;
`ifdef HOOP_SCORE_COMBO_TIMEOUT_EN
    int m_idle     = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int exp_hud();
        if (m_outcome == 1) return 2;
        if (m_outcome == 2) return 3;
        return (m_run > 0) ? 1 : 0;
    endfunction

    task automatic model_frame(input int hx, input int hy, input int px, input int py, input bit pz);
        bit respawn;
        bit rim;
        bit win;
        bit award;
        int cx;
        int cy;
        award_t a;
        if (pz) return;
        respawn    = (hy < m_prev_y);
        m_prev_y   = hy;
        rim        = m_rim_seen;
        m_rim_seen = 1'b0;
        cx  = px + PLAYER_W / 2;
        cy  = py + PLAYER_H / 2;
        win = (cx >= hx + RING_MARGIN_X) && (cx < hx + HOOP_W - RING_MARGIN_X) &&
              (cy >= hy + RING_TOP_Y) && (cy < hy + RING_TOP_Y + RING_H);
        award = 1'b0;
        if (respawn) begin
            if (m_outcome == 0) m_combo = 0;
            m_outcome = 0;
            m_run     = 0;
        end else if (m_outcome == 0) begin
            if (rim) begin
                m_outcome = 2;
                m_run     = 0;
                m_combo   = 0;
            end else if (win) begin
                m_run++;
                if (m_run >= MIN_INSIDE_FRAMES) begin
                    m_outcome = 1;
                    award     = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
`ifdef HOOP_SCORE_COMBO_TIMEOUT_EN
        if (award) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == COMBO_TIMEOUT_FRAMES) begin
                m_combo = 0;
                m_idle  = 0;
            end
        end
`endif
        if (award) begin
            a.steps   = m_combo + 1;
            m_score   = m_score + BASE_POINTS_DEC * a.steps;
            if (m_score > SCORE_CAP) m_score = SCORE_CAP;
            m_combo   = (m_combo + 1 > MAX_COMBO) ? MAX_COMBO : m_combo + 1;
            a.score_dec = m_score;
            a.combo     = m_combo;
            exp_q.push_back(a);
        end
    endtask

    // One frame: strobe, evaluation cycle, then a gap that may carry a rim touch.
    task automatic frame(input int hx, input int hy, input int px, input int py,
                         input bit pz, input bit rim, input int gap);
        @(negedge clk);
        startOfFrame   = 1'b1;
        hoopTopLeftX   = 11'(hx);
        hoopTopLeftY   = 11'(hy);
        playerTopLeftX = 11'(px);
        playerTopLeftY = 11'(py);
        @(negedge clk);
        startOfFrame = 1'b0;
        pause        = pz;
        model_frame(hx, hy, px, py, pz);
        @(negedge clk);
        pause = 1'b0;
        check("hoop_state", 32'(hoopState), 32'(exp_hud()));
        check("combo_frame", 32'(comboLevel), 32'(m_combo));
        rimCollision = rim;
        if (rim) m_rim_seen = 1'b1;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rimCollision = 1'b0;
        end
    endtask

    // Respawn the hoop far up, then hold the player in the opening for a pass.
    task automatic score_hoop(input int hx);
        frame(hx, -500, hx + 300, -500, 1'b0, 1'b0, 2);
        for (int k = 1; k <= MIN_INSIDE_FRAMES; k++) begin
            frame(hx, -500 + 10 * k, hx - 2, -500 + 10 * k + 2, 1'b0, 1'b0, 2);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every score strobe must match the oldest queued award.
    initial begin
        award_t a;
        forever begin
            @(negedge clk);
            if (scorePulse === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(scorePulse), 32'd0);
                end else begin
                    a = exp_q.pop_front();
                    check("combo_at_pulse", 32'(comboLevel), 32'(a.combo));
                    repeat (a.steps) @(negedge clk);
                    check("pulse_width", 32'(scorePulse), 32'd0);
                    check("score_after_award", 32'(score), 32'(to_bcd(a.score_dec)));
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hx;
        int hy;
        int px;
        int py;
        resetN         = 1'b0;
        startOfFrame   = 1'b0;
        pause          = 1'b0;
        rimCollision   = 1'b0;
        hoopTopLeftX   = '0;
        hoopTopLeftY   = '0;
        playerTopLeftX = '0;
        playerTopLeftY = '0;
        idle(3);
        check("reset_score", 32'(score), 32'h0);
        check("reset_pulse", 32'(scorePulse), 32'd0);
        check("reset_combo", 32'(comboLevel), 32'd0);
        check("reset_state", 32'(hoopState), 32'd0);
        resetN = 1'b1;
        idle(2);

        // First pass: hoop parked at (100,50), player centre at (114,68).
        for (int k = 0; k < 3; k++) frame(100, 50, 98, 52, 1'b0, 1'b0, 2);
        idle(4);
        check("first_score", 32'(score), 32'h0010);
        check("first_combo", 32'(comboLevel), 32'd1);

        // Four more clean passes: 10+20+30+40+50.
        for (int h = 0; h < 4; h++) score_hoop(100);
        idle(10);
        check("five_score", 32'(score), 32'h0150);
        check("five_combo", 32'(comboLevel), 32'd5);

        // Two frames inside, then a rim touch: the hoop is lost.
        frame(100, -500, 400, -500, 1'b0, 1'b0, 2);
        frame(100, -490, 98, -488, 1'b0, 1'b0, 2);
        frame(100, -480, 98, -478, 1'b0, 1'b1, 2);
        frame(100, -470, 98, -468, 1'b0, 1'b0, 2);
        check("rim_state", 32'(hoopState), 32'd3);
        check("rim_combo", 32'(comboLevel), 32'd0);
        frame(100, 480, 400, 480, 1'b0, 1'b0, 2);
        frame(100, -232, 400, -232, 1'b0, 1'b0, 2);
        check("rim_respawn_state", 32'(hoopState), 32'd0);
        check("rim_score_held", 32'(score), 32'h0150);

        // Build combo to 4, then let an armed hoop respawn unpassed.
        for (int h = 0; h < 4; h++) score_hoop(300);
        frame(300, -500, 600, -500, 1'b0, 1'b0, 2);
        frame(300, -600, 600, -600, 1'b0, 1'b0, 2);
        check("armed_respawn_combo", 32'(comboLevel), 32'd0);
        check("armed_respawn_state", 32'(hoopState), 32'd0);

        // Pause with the player inside: progress freezes, then resumes.
        frame(200, -700, 500, -700, 1'b0, 1'b0, 2);
        frame(200, -690, 198, -688, 1'b0, 1'b0, 2);
        for (int k = 0; k < 10; k++) frame(200, -690, 198, -688, 1'b1, 1'b0, 2);
        check("pause_state", 32'(hoopState), 32'd1);
        frame(200, -680, 198, -678, 1'b0, 1'b0, 2);
        frame(200, -670, 198, -668, 1'b0, 1'b0, 2);
        check("pause_award_state", 32'(hoopState), 32'd2);
        idle(4);

        // Randomised falling hoops with wandering player, pauses and rim hits.
        for (int ep = 0; ep < 25; ep++) begin
            hx = int'($urandom_range(0, 600));
            hy = -232 + int'($urandom_range(0, 40));
            while (hy < 480) begin
                if ($urandom_range(0, 9) < 7) begin
                    px = hx + RING_MARGIN_X + int'($urandom_range(0, 15)) - PLAYER_W / 2;
                    py = hy + RING_TOP_Y + int'($urandom_range(0, 19)) - PLAYER_H / 2;
                end else begin
                    px = hx + int'($urandom_range(0, 120)) - 60;
                    py = hy + int'($urandom_range(0, 120)) - 60;
                end
                frame(hx, hy, px, py, ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 14) == 0), int'($urandom_range(1, 4)));
                hy = hy + int'($urandom_range(20, 60));
            end
        end

        // Keep scoring until the score pins at its ceiling, then once more.
        while (m_score < SCORE_CAP) score_hoop(250);
        score_hoop(250);
        idle(20);
        check("saturated_score", 32'(score), 32'h9999);
        check("final_score", 32'(score), 32'(to_bcd(m_score)));
        check("award_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
